dmem_arbiter: RTL and testbench

Two-port arbiter that shares the single data memory (64-word RAM) between the processor's load/store port and a debug/loader port. Each cycle it grants at most one requester, drives the RAM address/data/write-enable, and returns read data one cycle later. Sits between `top`'s processor core and `dmem`. The debug port can preload or dump memory while the core runs, and can hold short locked bursts.

---
 rtl/dmem_arbiter_if.sv | 49 ++++
 rtl/dmem_arbiter.sv | 130 +++++++++++++
 tb/tb_dmem_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the arbiter, its two requesters (CPU load/store and debug/loader)
// and the shared data RAM.
interface dmem_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_gnt;
  logic        cpu_rvalid;
  logic [31:0] cpu_rdata;

  logic        dbg_req;
  logic        dbg_we;
  logic [31:0] dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_lock;
  logic        dbg_gnt;
  logic        dbg_rvalid;
  logic [31:0] dbg_rdata;

  logic        err;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  // Arbiter side.
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
    input  mem_rdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output err,
    output mem_addr, mem_wdata, mem_we
  );

  // Requester and RAM side.
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
    output mem_rdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  err,
    input  mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter sharing one data RAM between the CPU and a debug/loader port.
// Combinational grant, round-robin on ties, bounded debug lock, 1-cycle read response.
module dmem_arbiter #(
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned LOCK_MAX = 8,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input logic            i_clk,
  input logic            i_reset,
  dmem_arbiter_if.slave  io_bus
);

  localparam int unsigned CntW = $clog2(LOCK_MAX + 1);
  localparam logic [CntW-1:0] LockMax = CntW'(LOCK_MAX);
  localparam logic [29:0] DepthW = 30'(DEPTH);

  typedef enum logic {
    WinCpu,
    WinDbg
  } winner_e;

  winner_e         r_last_winner;
  logic            r_dbg_gnt_prev;
  logic [CntW-1:0] r_lock_cnt;
  logic            r_cpu_rvalid;
  logic [31:0]     r_cpu_rdata;
  logic            r_dbg_rvalid;
  logic [31:0]     r_dbg_rdata;
  logic            r_err;

  logic        w_cpu_gnt;
  logic        w_dbg_gnt;
  logic        w_any_gnt;
  logic        w_lock_hold;
  logic        w_force_cpu;
  logic        w_cpu_in_range;
  logic        w_dbg_in_range;
  logic        w_in_range;
  logic        w_sel_we;
  logic [31:0] w_rd_data;

  assign w_cpu_in_range = io_bus.cpu_addr[31:2] < DepthW;
  assign w_dbg_in_range = io_bus.dbg_addr[31:2] < DepthW;

  assign w_lock_hold = r_dbg_gnt_prev && io_bus.dbg_req && io_bus.dbg_lock;
  assign w_force_cpu = io_bus.cpu_req && (r_lock_cnt >= LockMax);

  // Grants are held off while reset is asserted so no write can slip through.
  always_comb begin
    w_cpu_gnt = 1'b0;
    w_dbg_gnt = 1'b0;
    if (!i_reset) begin
      w_cpu_gnt = 1'b0;
      w_dbg_gnt = 1'b0;
    end else if (io_bus.cpu_req && io_bus.dbg_req) begin
      if (w_force_cpu) begin
        w_cpu_gnt = 1'b1;
      end else if (w_lock_hold) begin
        w_dbg_gnt = 1'b1;
      end else if (r_last_winner == WinDbg) begin
        w_cpu_gnt = 1'b1;
      end else begin
        w_dbg_gnt = 1'b1;
      end
    end else if (io_bus.cpu_req) begin
      w_cpu_gnt = 1'b1;
    end else if (io_bus.dbg_req) begin
      w_dbg_gnt = 1'b1;
    end
  end

  assign w_any_gnt  = w_cpu_gnt | w_dbg_gnt;
  assign w_in_range = w_dbg_gnt ? w_dbg_in_range : w_cpu_in_range;
  assign w_sel_we   = w_dbg_gnt ? io_bus.dbg_we : io_bus.cpu_we;
  assign w_rd_data  = w_in_range ? io_bus.mem_rdata : ERR_DATA;

  // With no grant the RAM sees the CPU's address and data.
  assign io_bus.mem_addr  = w_dbg_gnt ? io_bus.dbg_addr : io_bus.cpu_addr;
  assign io_bus.mem_wdata = w_dbg_gnt ? io_bus.dbg_wdata : io_bus.cpu_wdata;
  assign io_bus.mem_we    = w_any_gnt && w_sel_we && w_in_range;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_last_winner  <= WinDbg;
      r_dbg_gnt_prev <= 1'b0;
      r_lock_cnt     <= '0;
      r_cpu_rvalid   <= 1'b0;
      r_cpu_rdata    <= '0;
      r_dbg_rvalid   <= 1'b0;
      r_dbg_rdata    <= '0;
      r_err          <= 1'b0;
    end else begin
      r_dbg_gnt_prev <= w_dbg_gnt;

      if (w_cpu_gnt) begin
        r_last_winner <= WinCpu;
      end else if (w_dbg_gnt) begin
        r_last_winner <= WinDbg;
      end

      // Only locked grants that actually starve the CPU count toward the limit.
      if (!w_dbg_gnt || !w_lock_hold) begin
        r_lock_cnt <= '0;
      end else if (io_bus.cpu_req && (r_lock_cnt != LockMax)) begin
        r_lock_cnt <= r_lock_cnt + 1'b1;
      end

      r_err <= w_any_gnt && !w_in_range;

      r_cpu_rvalid <= w_cpu_gnt && !io_bus.cpu_we;
      if (w_cpu_gnt && !io_bus.cpu_we) begin
        r_cpu_rdata <= w_rd_data;
      end

      r_dbg_rvalid <= w_dbg_gnt && !io_bus.dbg_we;
      if (w_dbg_gnt && !io_bus.dbg_we) begin
        r_dbg_rdata <= w_rd_data;
      end
    end
  end

  assign io_bus.cpu_gnt    = w_cpu_gnt;
  assign io_bus.cpu_rvalid = r_cpu_rvalid;
  assign io_bus.cpu_rdata  = r_cpu_rdata;
  assign io_bus.dbg_gnt    = w_dbg_gnt;
  assign io_bus.dbg_rvalid = r_dbg_rvalid;
  assign io_bus.dbg_rdata  = r_dbg_rdata;
  assign io_bus.err        = r_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a behavioural 64-word RAM hangs off the memory side,
// inputs change on the falling edge and outputs are sampled 1 ns later.
module tb_dmem_arbiter;

  logic clk;
  logic reset;

  dmem_arbiter_if bus ();

  dmem_arbiter #(
    .DEPTH    (64),
    .LOCK_MAX (8),
    .ERR_DATA (32'hDEADBEEF)
  ) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .io_bus  (bus)
  );

  logic [31:0] ram     [64];
  logic [31:0] exp_ram [64];

  assign bus.mem_rdata = ram[bus.mem_addr[7:2]];

  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr[7:2]] <= bus.mem_wdata;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic idle_inputs();
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = 32'h0;
    bus.cpu_wdata = 32'h0;
    bus.dbg_req   = 1'b0;
    bus.dbg_we    = 1'b0;
    bus.dbg_addr  = 32'h0;
    bus.dbg_wdata = 32'h0;
    bus.dbg_lock  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    bus.cpu_req = 1'b1;
    bus.cpu_we  = 1'b1;
    bus.dbg_req = 1'b1;
    @(negedge clk); #1;
    checks++; if (bus.cpu_gnt !== 1'b0) begin
      errors++; $display("FAIL reset_cpu_gnt: got %b want 0", bus.cpu_gnt); end
    checks++; if (bus.dbg_gnt !== 1'b0) begin
      errors++; $display("FAIL reset_dbg_gnt: got %b want 0", bus.dbg_gnt); end
    checks++; if (bus.mem_we !== 1'b0) begin
      errors++; $display("FAIL reset_mem_we: got %b want 0", bus.mem_we); end
    checks++; if (bus.cpu_rvalid !== 1'b0 || bus.dbg_rvalid !== 1'b0) begin
      errors++; $display("FAIL reset_rvalid: got cpu=%b dbg=%b want 0 0",
                         bus.cpu_rvalid, bus.dbg_rvalid); end
    checks++; if (bus.err !== 1'b0) begin
      errors++; $display("FAIL reset_err: got %b want 0", bus.err); end
    checks++; if (bus.cpu_rdata !== 32'h0 || bus.dbg_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_rdata: got cpu=%h dbg=%h want 0 0",
                         bus.cpu_rdata, bus.dbg_rdata); end
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      idle_inputs();
      bus.dbg_req   = 1'b1;
      bus.dbg_we    = 1'b1;
      bus.dbg_addr  = 32'(i * 4);
      bus.dbg_wdata = 32'hA500_0000 | 32'(i);
      exp_ram[i]    = 32'hA500_0000 | 32'(i);
      #1;
      checks++; if (bus.dbg_gnt !== 1'b1 || bus.cpu_gnt !== 1'b0) begin
        errors++; $display("FAIL fill_gnt[%0d]: got dbg=%b cpu=%b want 1 0",
                           i, bus.dbg_gnt, bus.cpu_gnt); end
      checks++; if (bus.mem_we !== 1'b1) begin
        errors++; $display("FAIL fill_mem_we[%0d]: got %b want 1", i, bus.mem_we); end
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (bus.dbg_rvalid !== 1'b0) begin
      errors++; $display("FAIL write_no_rvalid: got %b want 0", bus.dbg_rvalid); end
  endtask

  task automatic test_cpu_read();
    @(negedge clk);
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 32'h8;
    #1;
    checks++; if (bus.cpu_gnt !== 1'b1 || bus.dbg_gnt !== 1'b0) begin
      errors++; $display("FAIL cpu_read_gnt: got cpu=%b dbg=%b want 1 0",
                         bus.cpu_gnt, bus.dbg_gnt); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (bus.cpu_rvalid !== 1'b1) begin
      errors++; $display("FAIL cpu_read_rvalid: got %b want 1", bus.cpu_rvalid); end
    checks++; if (bus.cpu_rdata !== 32'hA500_0002) begin
      errors++; $display("FAIL cpu_read_rdata: got %h want a5000002", bus.cpu_rdata); end
    checks++; if (bus.dbg_gnt !== 1'b0 || bus.err !== 1'b0) begin
      errors++; $display("FAIL cpu_read_side: got dbg_gnt=%b err=%b want 0 0",
                         bus.dbg_gnt, bus.err); end
    // Unaligned address: low bits dropped, same word, no error.
    @(negedge clk);
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 32'hB;
    #1;
    checks++; if (bus.cpu_rvalid !== 1'b0 || bus.cpu_rdata !== 32'hA500_0002) begin
      errors++; $display("FAIL rdata_hold: got rvalid=%b rdata=%h want 0 a5000002",
                         bus.cpu_rvalid, bus.cpu_rdata); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 32'hA500_0002 ||
                  bus.err !== 1'b0) begin
      errors++; $display("FAIL unaligned_read: got rvalid=%b rdata=%h err=%b want 1 a5000002 0",
                         bus.cpu_rvalid, bus.cpu_rdata, bus.err); end
  endtask

  task automatic test_round_robin();
    logic [5:0] exp_dbg;
    exp_dbg = 6'b010101;  // bit 0 first: CPU won last, so debug wins the first tie
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.cpu_req   = 1'b1;
      bus.cpu_we    = 1'b1;
      bus.cpu_addr  = 32'h10;
      bus.cpu_wdata = 32'h1111_1111;
      bus.dbg_req   = 1'b1;
      bus.dbg_we    = 1'b1;
      bus.dbg_addr  = 32'h14;
      bus.dbg_wdata = 32'h2222_2222;
      #1;
      checks++; if (bus.dbg_gnt !== exp_dbg[i] || bus.cpu_gnt !== !exp_dbg[i]) begin
        errors++; $display("FAIL rr_gnt[%0d]: got cpu=%b dbg=%b want %b %b",
                           i, bus.cpu_gnt, bus.dbg_gnt, !exp_dbg[i], exp_dbg[i]); end
    end
    exp_ram[4] = 32'h1111_1111;
    exp_ram[5] = 32'h2222_2222;
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (ram[4] !== 32'h1111_1111 || ram[5] !== 32'h2222_2222) begin
      errors++; $display("FAIL rr_ram: got ram4=%h ram5=%h want 11111111 22222222",
                         ram[4], ram[5]); end
    checks++; if (bus.cpu_rvalid !== 1'b0 || bus.dbg_rvalid !== 1'b0) begin
      errors++; $display("FAIL rr_no_rvalid: got cpu=%b dbg=%b want 0 0",
                         bus.cpu_rvalid, bus.dbg_rvalid); end
  endtask

  task automatic test_raw();
    @(negedge clk);
    bus.dbg_req   = 1'b1;
    bus.dbg_we    = 1'b1;
    bus.dbg_addr  = 32'h20;
    bus.dbg_wdata = 32'hCAFE_F00D;
    #1;
    checks++; if (bus.dbg_gnt !== 1'b1 || bus.mem_we !== 1'b1) begin
      errors++; $display("FAIL raw_dbg_write: got gnt=%b we=%b want 1 1",
                         bus.dbg_gnt, bus.mem_we); end
    exp_ram[8] = 32'hCAFE_F00D;
    @(negedge clk);
    idle_inputs();
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 32'h20;
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL raw_rdata: got rvalid=%b rdata=%h want 1 cafef00d",
                         bus.cpu_rvalid, bus.cpu_rdata); end
  endtask

  task automatic test_lock();
    logic [11:0] exp_dbg;
    // First grant plus 8 locked, then one forced CPU cycle, then debug again.
    exp_dbg = 12'b1101_1111_1111;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      bus.cpu_req  = 1'b1;
      bus.cpu_we   = 1'b0;
      bus.cpu_addr = 32'h0;
      bus.dbg_req  = 1'b1;
      bus.dbg_we   = 1'b0;
      bus.dbg_addr = 32'h4;
      bus.dbg_lock = 1'b1;
      #1;
      checks++; if (bus.dbg_gnt !== exp_dbg[i] || bus.cpu_gnt !== !exp_dbg[i]) begin
        errors++; $display("FAIL lock_gnt[%0d]: got cpu=%b dbg=%b want %b %b",
                           i, bus.cpu_gnt, bus.dbg_gnt, !exp_dbg[i], exp_dbg[i]); end
      if (i == 10) begin
        checks++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 32'hA500_0000) begin
          errors++; $display("FAIL lock_cpu_read: got rvalid=%b rdata=%h want 1 a5000000",
                             bus.cpu_rvalid, bus.cpu_rdata); end
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_out_of_range();
    @(negedge clk);
    bus.dbg_req  = 1'b1;
    bus.dbg_addr = 32'h100;
    #1;
    checks++; if (bus.dbg_gnt !== 1'b1 || bus.mem_we !== 1'b0) begin
      errors++; $display("FAIL oor_read_gnt: got gnt=%b we=%b want 1 0",
                         bus.dbg_gnt, bus.mem_we); end
    @(negedge clk);
    idle_inputs();
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 32'h104;
    bus.cpu_wdata = 32'h0;
    #1;
    checks++; if (bus.dbg_rvalid !== 1'b1 || bus.dbg_rdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL oor_read_data: got rvalid=%b rdata=%h want 1 deadbeef",
                         bus.dbg_rvalid, bus.dbg_rdata); end
    checks++; if (bus.err !== 1'b1) begin
      errors++; $display("FAIL oor_read_err: got %b want 1", bus.err); end
    checks++; if (bus.cpu_gnt !== 1'b1 || bus.mem_we !== 1'b0) begin
      errors++; $display("FAIL oor_write_we: got gnt=%b we=%b want 1 0",
                         bus.cpu_gnt, bus.mem_we); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (bus.err !== 1'b1 || bus.cpu_rvalid !== 1'b0) begin
      errors++; $display("FAIL oor_write_err: got err=%b rvalid=%b want 1 0",
                         bus.err, bus.cpu_rvalid); end
    @(negedge clk);
    #1;
    checks++; if (bus.err !== 1'b0) begin
      errors++; $display("FAIL err_pulse: got %b want 0", bus.err); end
    for (int i = 0; i < 64; i++) begin
      checks++; if (ram[i] !== exp_ram[i]) begin
        errors++; $display("FAIL ram_word[%0d]: got %h want %h", i, ram[i], exp_ram[i]); end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 32'h10;
    #1;
    checks++; if (bus.cpu_gnt !== 1'b1) begin
      errors++; $display("FAIL mid_read_gnt: got %b want 1", bus.cpu_gnt); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 32'h1111_1111) begin
      errors++; $display("FAIL mid_pre_reset: got rvalid=%b rdata=%h want 1 11111111",
                         bus.cpu_rvalid, bus.cpu_rdata); end
    reset         = 1'b0;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 32'h0;
    bus.cpu_wdata = 32'hFFFF_FFFF;
    bus.dbg_req   = 1'b1;
    #1;
    checks++; if (bus.cpu_rvalid !== 1'b0 || bus.cpu_rdata !== 32'h0) begin
      errors++; $display("FAIL mid_reset_rvalid: got rvalid=%b rdata=%h want 0 0",
                         bus.cpu_rvalid, bus.cpu_rdata); end
    checks++; if (bus.cpu_gnt !== 1'b0 || bus.dbg_gnt !== 1'b0 || bus.mem_we !== 1'b0) begin
      errors++; $display("FAIL mid_reset_gnt: got cpu=%b dbg=%b we=%b want 0 0 0",
                         bus.cpu_gnt, bus.dbg_gnt, bus.mem_we); end
    @(negedge clk);
    reset       = 1'b1;
    bus.cpu_we  = 1'b0;
    #1;
    checks++; if (bus.cpu_gnt !== 1'b1 || bus.dbg_gnt !== 1'b0) begin
      errors++; $display("FAIL post_reset_tie: got cpu=%b dbg=%b want 1 0",
                         bus.cpu_gnt, bus.dbg_gnt); end
    checks++; if (ram[0] !== exp_ram[0]) begin
      errors++; $display("FAIL reset_no_write: got %h want %h", ram[0], exp_ram[0]); end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_cpu_read();
    test_round_robin();
    test_raw();
    test_lock();
    test_out_of_range();
    test_reset_mid();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
